// File: rtl/maq_h_if.sv
// Hour-stage bundle: minute carry and adjust controls in, BCD hour, pm flag and day carry out.
interface maq_h_if;
    logic       incrementa_hora;
    logic       ajuste_en;
    logic       ajuste_inc;
    logic       ajuste_dec;
    logic [3:0] bcd_h_lsd;
    logic [1:0] bcd_h_msd;
    logic       pm;
    logic       incrementa_dia;

    modport master (
        output incrementa_hora, ajuste_en, ajuste_inc, ajuste_dec,
        input  bcd_h_lsd, bcd_h_msd, pm, incrementa_dia
    );

    modport slave (
        input  incrementa_hora, ajuste_en, ajuste_inc, ajuste_dec,
        output bcd_h_lsd, bcd_h_msd, pm, incrementa_dia
    );
endinterface

// File: rtl/maq_h.sv
// Hour stage of the clock chain: BCD hour counter (24h or 12h with pm), button adjust, day carry.
module maq_h #(
    parameter bit MODO_24H = 1'b1
) (
    input  logic     clk,
    input  logic     rst,
    maq_h_if.slave   bus
);
    typedef struct packed {
        logic       pm;
        logic [1:0] msd;
        logic [3:0] lsd;
    } hora_t;

    // 24h resets to 00; 12h resets to 12 AM
    localparam hora_t RST_HORA = MODO_24H ? hora_t'({1'b0, 2'd0, 4'd0})
                                          : hora_t'({1'b0, 2'd1, 4'd2});

    hora_t hora;
    logic  inc_q;
    logic  dec_q;
    logic  cuenta;
    logic  sube;
    logic  baja;
    logic  fin_dia;

    function automatic logic pm_24h(input logic [1:0] msd, input logic [3:0] lsd);
        return (msd == 2'd2) || (msd == 2'd1 && lsd >= 4'd2);
    endfunction

    function automatic hora_t hora_inc(input hora_t h);
        hora_t r;
        r = h;
        if (MODO_24H) begin
            if (h.msd == 2'd2 && h.lsd == 4'd3) begin
                r.msd = 2'd0;
                r.lsd = 4'd0;
            end else if (h.lsd == 4'd9) begin
                r.msd = h.msd + 2'd1;
                r.lsd = 4'd0;
            end else begin
                r.lsd = h.lsd + 4'd1;
            end
            r.pm = pm_24h(r.msd, r.lsd);
        end else begin
            if (h.msd == 2'd1 && h.lsd == 4'd2) begin
                r.msd = 2'd0;
                r.lsd = 4'd1;
            end else if (h.msd == 2'd1 && h.lsd == 4'd1) begin
                r.lsd = 4'd2;
                r.pm  = ~h.pm;
            end else if (h.lsd == 4'd9) begin
                r.msd = 2'd1;
                r.lsd = 4'd0;
            end else begin
                r.lsd = h.lsd + 4'd1;
            end
        end
        return r;
    endfunction

    function automatic hora_t hora_dec(input hora_t h);
        hora_t r;
        r = h;
        if (MODO_24H) begin
            if (h.msd == 2'd0 && h.lsd == 4'd0) begin
                r.msd = 2'd2;
                r.lsd = 4'd3;
            end else if (h.lsd == 4'd0) begin
                r.msd = h.msd - 2'd1;
                r.lsd = 4'd9;
            end else begin
                r.lsd = h.lsd - 4'd1;
            end
            r.pm = pm_24h(r.msd, r.lsd);
        end else begin
            // 12 is the first hour of each half, so stepping back from it crosses halves
            if (h.msd == 2'd0 && h.lsd == 4'd1) begin
                r.msd = 2'd1;
                r.lsd = 4'd2;
            end else if (h.msd == 2'd1 && h.lsd == 4'd2) begin
                r.lsd = 4'd1;
                r.pm  = ~h.pm;
            end else if (h.msd == 2'd1 && h.lsd == 4'd0) begin
                r.msd = 2'd0;
                r.lsd = 4'd9;
            end else begin
                r.lsd = h.lsd - 4'd1;
            end
        end
        return r;
    endfunction

    always_comb begin
        cuenta  = bus.incrementa_hora & ~bus.ajuste_en;
        sube    = bus.ajuste_en & bus.ajuste_inc & ~inc_q & ~(bus.ajuste_dec & ~dec_q);
        baja    = bus.ajuste_en & bus.ajuste_dec & ~dec_q & ~(bus.ajuste_inc & ~inc_q);
        fin_dia = MODO_24H ? (hora.msd == 2'd2 && hora.lsd == 4'd3)
                           : (hora.pm && hora.msd == 2'd1 && hora.lsd == 4'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hora  <= RST_HORA;
            inc_q <= 1'b0;
            dec_q <= 1'b0;
        end else begin
            inc_q <= bus.ajuste_inc;
            dec_q <= bus.ajuste_dec;
            if (cuenta || sube) begin
                hora <= hora_inc(hora);
            end else if (baja) begin
                hora <= hora_dec(hora);
            end
        end
    end

    assign bus.bcd_h_lsd      = hora.lsd;
    assign bus.bcd_h_msd      = hora.msd;
    assign bus.pm             = hora.pm;
    assign bus.incrementa_dia = cuenta & fin_dia;
endmodule
